// File: rtl/demux16x1_capture_if.sv
// Serial-in / word-out bundle for demux16x1_capture.
// master drives the bit stream and consumes words; slave is the demux.
interface demux16x1_capture_if #(
    parameter int N_OUT = 16
);
    localparam int SEL_W = $clog2(N_OUT);

    logic             auto;
    logic [SEL_W-1:0] s;
    logic             din;
    logic             din_valid;
    logic             din_ready;
    logic [N_OUT-1:0] dataout;
    logic             word_valid;
    logic             word_ready;

    modport master (
        output auto, s, din, din_valid, word_ready,
        input  din_ready, dataout, word_valid
    );

    modport slave (
        input  auto, s, din, din_valid, word_ready,
        output din_ready, dataout, word_valid
    );
endinterface

// File: rtl/demux16x1_capture.sv
// Registered 1-to-N_OUT demux: direct select or auto-pointer word fill.
// Optional sel_onehot output enabled by DEMUX_ONEHOT_EN.
module demux16x1_capture #(
    parameter int N_OUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    demux16x1_capture_if.slave bus
`ifdef DEMUX_ONEHOT_EN
    ,
    output logic [N_OUT-1:0] sel_onehot
`endif
);
    localparam int SEL_W = $clog2(N_OUT);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_OUT-1:0] data_q, data_d;
    logic             xfer;
    logic             wr_en;
    logic [SEL_W-1:0] wr_idx;
`ifdef DEMUX_ONEHOT_EN
    logic [N_OUT-1:0] oh_q, oh_d;
`endif

    assign bus.din_ready  = (state_q != HOLD);
    assign bus.word_valid = (state_q == HOLD);
    assign bus.dataout    = data_q;
    assign xfer           = bus.din_valid && bus.din_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        wr_en   = 1'b0;
        wr_idx  = bus.s;
`ifdef DEMUX_ONEHOT_EN
        oh_d    = oh_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (bus.auto) begin
                        wr_idx  = '0;
                        ptr_d   = SEL_W'(1);
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (xfer) begin
                    wr_en  = 1'b1;
                    wr_idx = ptr_q;
                    // Power-of-2 width: increment wraps to 0 on the last bit
                    ptr_d  = ptr_q + SEL_W'(1);
                    if (ptr_q == LAST) state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.word_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) data_d[wr_idx] = bus.din;
`ifdef DEMUX_ONEHOT_EN
        if (wr_en) begin
            oh_d         = '0;
            oh_d[wr_idx] = 1'b1;
        end
`endif

        if (clear) begin
            state_d = IDLE;
            ptr_d   = '0;
            data_d  = '0;
`ifdef DEMUX_ONEHOT_EN
            oh_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
`ifdef DEMUX_ONEHOT_EN
            oh_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
`ifdef DEMUX_ONEHOT_EN
            oh_q    <= oh_d;
`endif
        end
    end

`ifdef DEMUX_ONEHOT_EN
    assign sel_onehot = oh_q;
`endif
endmodule

// File: tb/tb_demux16x1_capture.sv
// Directed bench for demux16x1_capture (direct, auto, handshake, abort).
// Builds with or without DEMUX_ONEHOT_EN.
module tb_demux16x1_capture;
    logic clk = 1'b0;
    logic rst;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] word;
`ifdef DEMUX_ONEHOT_EN
    logic [15:0] sel_onehot;
`endif

    always #5 clk = ~clk;

    demux16x1_capture_if #(.N_OUT(16)) bus ();

    demux16x1_capture #(.N_OUT(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
`ifdef DEMUX_ONEHOT_EN
        ,
        .sel_onehot (sel_onehot)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        clear          = 1'b0;
        bus.auto       = 1'b0;
        bus.s          = '0;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.word_ready = 1'b0;
        tick();
        tick();
        chk("rst_data", 32'(bus.dataout), 32'h0000);
        chk("rst_wv", 32'(bus.word_valid), 0);
        chk("rst_rdy", 32'(bus.din_ready), 1);
`ifdef DEMUX_ONEHOT_EN
        chk("rst_oh", 32'(sel_onehot), 32'h0000);
`endif
        rst = 1'b0;
        tick();

        // direct mode
        bus.din_valid = 1'b1;
        bus.din = 1'b1;
        bus.s = 4'd0;
        tick();
        chk("dir_lat", 32'(bus.dataout), 32'h0001);
        bus.s = 4'd5;
        tick();
        bus.s = 4'd15;
        tick();
        bus.din_valid = 1'b0;
        chk("dir_data", 32'(bus.dataout), 32'h8021);
        chk("dir_wv", 32'(bus.word_valid), 0);
        bus.s = 4'd3;
        tick();
        chk("dir_novalid", 32'(bus.dataout), 32'h8021);
        bus.din_valid = 1'b1;
        bus.din = 1'b0;
        bus.s = 4'd5;
        tick();
        chk("dir_zero", 32'(bus.dataout), 32'h8001);
        bus.din = 1'b1;
        bus.s = 4'd9;
        tick();
        bus.din_valid = 1'b0;
        chk("dir_s9", 32'(bus.dataout), 32'h8201);
        chk("dir_rdy", 32'(bus.din_ready), 1);
`ifdef DEMUX_ONEHOT_EN
        chk("oh_s9", 32'(sel_onehot), 32'h0200);
        tick();
        chk("oh_hold", 32'(sel_onehot), 32'h0200);
`endif

        // auto fill A5C3
        word = 16'hA5C3;
        bus.auto = 1'b1;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.din = word[i];
            tick();
            if (i == 14) chk("fill_wv15", 32'(bus.word_valid), 0);
        end
        bus.din = 1'b0;
        chk("fill_data", 32'(bus.dataout), 32'hA5C3);
        chk("fill_wv", 32'(bus.word_valid), 1);
        chk("fill_rdy", 32'(bus.din_ready), 0);
`ifdef DEMUX_ONEHOT_EN
        chk("oh_last", 32'(sel_onehot), 32'h8000);
`endif

        // HOLD ignores din_valid and auto
        bus.auto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_wv", 32'(bus.word_valid), 1);
            chk("hold_rdy", 32'(bus.din_ready), 0);
            chk("hold_data", 32'(bus.dataout), 32'hA5C3);
        end
        bus.din_valid = 1'b0;

        // handshake
        bus.word_ready = 1'b1;
        tick();
        chk("hs_wv", 32'(bus.word_valid), 0);
        chk("hs_rdy", 32'(bus.din_ready), 1);
        chk("hs_keep", 32'(bus.dataout), 32'hA5C3);
        tick();
        chk("wr_idle", 32'(bus.word_valid), 0);
        bus.word_ready = 1'b0;

        // second word 00FF, auto dropped mid-fill
        word = 16'h00FF;
        bus.auto = 1'b1;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.din = word[i];
            if (i == 3) bus.auto = 1'b0;
            tick();
        end
        bus.din_valid = 1'b0;
        chk("w2_data", 32'(bus.dataout), 32'h00FF);
        chk("w2_wv", 32'(bus.word_valid), 1);
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        chk("w2_hs", 32'(bus.word_valid), 0);

        // abort after 7 bits, clear collides with din_valid
        word = 16'h0055;
        bus.auto = 1'b1;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.din = word[i];
            tick();
        end
        chk("ab_part", 32'(bus.dataout), 32'h00D5);
        bus.din = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.din_valid = 1'b0;
        chk("ab_data", 32'(bus.dataout), 32'h0000);
        chk("ab_wv", 32'(bus.word_valid), 0);
        chk("ab_rdy", 32'(bus.din_ready), 1);
`ifdef DEMUX_ONEHOT_EN
        chk("ab_oh", 32'(sel_onehot), 32'h0000);
`endif
        bus.auto = 1'b0;
        bus.din_valid = 1'b1;
        bus.s = 4'd3;
        tick();
        bus.din_valid = 1'b0;
        chk("ab_idle", 32'(bus.dataout), 32'h0008);

        // clear in HOLD
        bus.auto = 1'b1;
        bus.din_valid = 1'b1;
        bus.din = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        bus.din_valid = 1'b0;
        chk("ch_full", 32'(bus.dataout), 32'hFFFF);
        chk("ch_wv1", 32'(bus.word_valid), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ch_wv0", 32'(bus.word_valid), 0);
        chk("ch_data", 32'(bus.dataout), 32'h0000);

        // reset mid-fill
        bus.din_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("rm_part", 32'(bus.dataout), 32'h000F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.din_valid = 1'b0;
        chk("rm_data", 32'(bus.dataout), 32'h0000);
        chk("rm_rdy", 32'(bus.din_ready), 1);
        bus.auto = 1'b0;
        bus.din_valid = 1'b1;
        bus.s = 4'd15;
        tick();
        bus.din_valid = 1'b0;
        chk("rm_idle", 32'(bus.dataout), 32'h8000);
        chk("rm_wv", 32'(bus.word_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
